// File: rtl/xbar_pkg.sv
// xbar_pkg: constants, types and helpers shared by the crossbar scheduler.
//   N_PORTS     - number of crossbar input and output ports
//   PORT_W      - width of a port index
//   CNT_W       - width of one per-output contention counter
//   port_idx_t  - port index type
//   rr_next     - next round-robin index after a winner, wrapping mod N_PORTS
//   two_or_more - true when a request vector has at least two bits set
package xbar_pkg;

  localparam int N_PORTS = 4;
  localparam int PORT_W  = 2;
  localparam int CNT_W   = 16;

  typedef logic [PORT_W-1:0] port_idx_t;

  function automatic port_idx_t rr_next(input port_idx_t idx);
    return port_idx_t'((int'(idx) + 1) % N_PORTS);
  endfunction

  function automatic logic two_or_more(input logic [N_PORTS-1:0] vec);
    int ones;
    ones = 0;
    for (int i = 0; i < N_PORTS; i++) begin
      ones = ones + int'(vec[i]);
    end
    return (ones >= 2);
  endfunction

endpackage

// File: rtl/xbar_scheduler_if.sv
// xbar_scheduler_if: groups the scheduler's request, crossbar-control and
// statistics signals.
//   req_valid      - per input: a cell is waiting
//   req_port       - per input: destination output (PORT_W bits per input)
//   out_ready      - per output: can accept a cell this cycle
//   out_enable     - per output: administratively enabled
//   clr_stats      - synchronous clear of all contention counters
//   grant          - per input: cell transfers at this rising edge
//   xbar_valid     - crossbar valid_in (equals grant)
//   xbar_port      - crossbar out_port (req_port where granted, else 0)
//   contention_cnt - CNT_W bits per output, saturating contention counters
// Modports: master drives requests (queues / bench), slave is the scheduler.
interface xbar_scheduler_if;
  import xbar_pkg::*;

  logic [N_PORTS-1:0]        req_valid;
  logic [N_PORTS*PORT_W-1:0] req_port;
  logic [N_PORTS-1:0]        out_ready;
  logic [N_PORTS-1:0]        out_enable;
  logic                      clr_stats;
  logic [N_PORTS-1:0]        grant;
  logic [N_PORTS-1:0]        xbar_valid;
  logic [N_PORTS*PORT_W-1:0] xbar_port;
  logic [N_PORTS*CNT_W-1:0]  contention_cnt;

  modport master (
    output req_valid, req_port, out_ready, out_enable, clr_stats,
    input  grant, xbar_valid, xbar_port, contention_cnt
  );

  modport slave (
    input  req_valid, req_port, out_ready, out_enable, clr_stats,
    output grant, xbar_valid, xbar_port, contention_cnt
  );

endinterface

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter for one crossbar output.
//   clk, rst_n - clock and asynchronous active-low reset
//   req        - one bit per input currently requesting this output
//   enable     - output is ready and enabled; no grant when low
//   gnt        - one-hot grant (or zero), combinational in the same cycle
// The search starts at the pointer and wraps; after a grant the pointer moves
// to the input just past the winner, and it holds when nothing is granted.
module rr_arbiter4 import xbar_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_PORTS-1:0] req,
  input  logic               enable,
  output logic [N_PORTS-1:0] gnt
);

  port_idx_t ptr;
  port_idx_t idx;
  port_idx_t win_idx;
  logic      found;

  // Scan from ptr upward; PORT_W-bit addition wraps naturally at N_PORTS.
  always_comb begin
    gnt     = '0;
    idx     = ptr;
    win_idx = ptr;
    found   = 1'b0;
    for (int off = 0; off < N_PORTS; off++) begin
      idx = ptr + port_idx_t'(off);
      if (enable && !found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    if (found) begin
      gnt[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= rr_next(win_idx);
    end
  end

endmodule

// File: rtl/xbar_scheduler.sv
// xbar_scheduler: conflict-free scheduler in front of the 4x4 cell crossbar.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - xbar_scheduler_if.slave: requests, output qualifiers,
//                grants, crossbar controls and contention statistics
// Each output owns a round-robin arbiter fed by the decoded destination of
// every valid input. Because an input names exactly one output, OR-ing the
// per-output grants yields at most one grant per input.
module xbar_scheduler import xbar_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  xbar_scheduler_if.slave  bus
);

  logic [N_PORTS-1:0]        out_req [N_PORTS];
  logic [N_PORTS-1:0]        out_gnt [N_PORTS];
  logic [N_PORTS-1:0]        arb_en;
  logic [N_PORTS-1:0]        grant_w;
  logic [N_PORTS*PORT_W-1:0] port_w;
  logic [CNT_W-1:0]          cnt_q [N_PORTS];
  logic [N_PORTS*CNT_W-1:0]  cnt_flat;

  // out_req[j][i]: input i has a valid cell destined for output j.
  always_comb begin
    for (int j = 0; j < N_PORTS; j++) begin
      out_req[j] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        out_req[j][i] = bus.req_valid[i] &&
                        (bus.req_port[i*PORT_W +: PORT_W] == port_idx_t'(j));
      end
    end
  end

  assign arb_en = bus.out_ready & bus.out_enable;

  for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
    rr_arbiter4 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (out_req[j]),
      .enable (arb_en[j]),
      .gnt    (out_gnt[j])
    );
  end

  always_comb begin
    grant_w = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      grant_w = grant_w | out_gnt[j];
    end
  end

  // Only granted inputs pass their destination to the crossbar.
  always_comb begin
    port_w = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant_w[i]) begin
        port_w[i*PORT_W +: PORT_W] = bus.req_port[i*PORT_W +: PORT_W];
      end
    end
  end

  assign bus.grant      = grant_w;
  assign bus.xbar_valid = grant_w;
  assign bus.xbar_port  = port_w;

  // Contention is counted whether or not the output can accept, saturates at
  // all-ones, and a clear takes priority over a same-cycle increment.
  for (genvar j = 0; j < N_PORTS; j++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[j] <= '0;
      end else if (bus.clr_stats) begin
        cnt_q[j] <= '0;
      end else if (two_or_more(out_req[j]) && (cnt_q[j] != '1)) begin
        cnt_q[j] <= cnt_q[j] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int j = 0; j < N_PORTS; j++) begin
      cnt_flat[j*CNT_W +: CNT_W] = cnt_q[j];
    end
  end

  assign bus.contention_cnt = cnt_flat;

endmodule

// File: tb/tb_xbar_scheduler.sv
// tb_xbar_scheduler: directed self-checking bench for xbar_scheduler.
// Inputs change 1 time unit after a rising edge; grants and counters are
// sampled a further 1 unit later, well away from either clock edge.
module tb_xbar_scheduler;
  import xbar_pkg::*;

  logic clk;
  logic rst_n;
  int   checks_total;
  int   checks_passed;

  xbar_scheduler_if bus ();

  xbar_scheduler dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_of(input int j);
    return bus.contention_cnt[j*CNT_W +: CNT_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.req_valid  = 4'h0;
    bus.req_port   = 8'h00;
    bus.out_ready  = 4'hF;
    bus.out_enable = 4'hF;
    bus.clr_stats  = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    #1;
    checks_total++;
    if (bus.grant !== 4'h0) $display("FAIL reset_grant: got %b expected 0000", bus.grant);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_valid !== 4'h0) $display("FAIL reset_xbar_valid: got %b expected 0000", bus.xbar_valid);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_port !== 8'h00) $display("FAIL reset_xbar_port: got %h expected 00", bus.xbar_port);
    else checks_passed++;
    checks_total++;
    if (bus.contention_cnt !== 64'h0) $display("FAIL reset_cnt: got %h expected 0", bus.contention_cnt);
    else checks_passed++;
  endtask

  task automatic test_permutation();
    tick();
    // in0->2, in1->3, in2->0, in3->1
    bus.req_valid = 4'hF;
    bus.req_port  = 8'b01_00_11_10;
    #1;
    checks_total++;
    if (bus.grant !== 4'hF) $display("FAIL perm_grant: got %b expected 1111", bus.grant);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_valid !== 4'hF) $display("FAIL perm_xbar_valid: got %b expected 1111", bus.xbar_valid);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_port !== 8'h4E) $display("FAIL perm_xbar_port: got %h expected 4e", bus.xbar_port);
    else checks_passed++;
    tick();
    bus.req_valid = 4'h0;
    checks_total++;
    if (bus.contention_cnt !== 64'h0) $display("FAIL perm_cnt: got %h expected 0", bus.contention_cnt);
    else checks_passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req_valid = 4'hF;
    bus.req_port  = 8'h55;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks_total++;
      if (bus.grant !== exp_seq[k]) $display("FAIL rr_grant[%0d]: got %b expected %b", k, bus.grant, exp_seq[k]);
      else checks_passed++;
      checks_total++;
      if (cnt_of(1) !== 16'(k)) $display("FAIL rr_cnt1[%0d]: got %0d expected %0d", k, cnt_of(1), k);
      else checks_passed++;
      tick();
    end
    checks_total++;
    if (cnt_of(1) !== 16'd5) $display("FAIL rr_cnt1_final: got %0d expected 5", cnt_of(1));
    else checks_passed++;
  endtask

  task automatic test_async_reset();
    // Round-robin on output 1 continues: pointer now sits at input 1.
    #1;
    checks_total++;
    if (bus.grant !== 4'b0010) $display("FAIL ar_pre_grant1: got %b expected 0010", bus.grant);
    else checks_passed++;
    tick();
    #1;
    checks_total++;
    if (bus.grant !== 4'b0100) $display("FAIL ar_pre_grant2: got %b expected 0100", bus.grant);
    else checks_passed++;
    #1;
    rst_n = 1'b0;
    #1;
    checks_total++;
    if (cnt_of(1) !== 16'd0) $display("FAIL ar_cnt_cleared: got %0d expected 0", cnt_of(1));
    else checks_passed++;
    checks_total++;
    if (bus.grant !== 4'b0001) $display("FAIL ar_in_reset_grant: got %b expected 0001", bus.grant);
    else checks_passed++;
    tick();
    rst_n = 1'b1;
    #1;
    checks_total++;
    if (bus.grant !== 4'b0001) $display("FAIL ar_release_grant: got %b expected 0001", bus.grant);
    else checks_passed++;
    checks_total++;
    if (cnt_of(1) !== 16'd0) $display("FAIL ar_cnt_hold: got %0d expected 0", cnt_of(1));
    else checks_passed++;
    tick();
    #1;
    checks_total++;
    if (bus.grant !== 4'b0010) $display("FAIL ar_after_grant: got %b expected 0010", bus.grant);
    else checks_passed++;
    tick();
    bus.req_valid = 4'h0;
  endtask

  task automatic test_backpressure();
    bus.req_valid = 4'b0101;
    bus.req_port  = 8'b00_11_00_11;
    bus.out_ready = 4'b0111;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks_total++;
      if (bus.grant !== 4'h0) $display("FAIL bp_blocked[%0d]: got %b expected 0000", k, bus.grant);
      else checks_passed++;
      tick();
    end
    checks_total++;
    if (cnt_of(3) !== 16'd5) $display("FAIL bp_cnt3: got %0d expected 5", cnt_of(3));
    else checks_passed++;
    bus.out_ready = 4'hF;
    #1;
    checks_total++;
    if (bus.grant !== 4'b0001) $display("FAIL bp_first: got %b expected 0001", bus.grant);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_port !== 8'h03) $display("FAIL bp_first_port: got %h expected 03", bus.xbar_port);
    else checks_passed++;
    tick();
    bus.req_valid = 4'b0100;
    #1;
    checks_total++;
    if (bus.grant !== 4'b0100) $display("FAIL bp_second: got %b expected 0100", bus.grant);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_port !== 8'h30) $display("FAIL bp_second_port: got %h expected 30", bus.xbar_port);
    else checks_passed++;
    checks_total++;
    if (cnt_of(3) !== 16'd6) $display("FAIL bp_cnt3_after: got %0d expected 6", cnt_of(3));
    else checks_passed++;
    tick();
    bus.req_valid = 4'h0;
    checks_total++;
    if (cnt_of(3) !== 16'd6) $display("FAIL bp_cnt3_single: got %0d expected 6", cnt_of(3));
    else checks_passed++;
  endtask

  task automatic test_disable();
    bus.out_enable = 4'b1101;
    bus.req_valid  = 4'b1010;
    bus.req_port   = 8'b00_00_01_00;
    #1;
    checks_total++;
    if (bus.grant !== 4'b1000) $display("FAIL dis_grant: got %b expected 1000", bus.grant);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_valid !== 4'b1000) $display("FAIL dis_xbar_valid: got %b expected 1000", bus.xbar_valid);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_port !== 8'h00) $display("FAIL dis_xbar_port: got %h expected 00", bus.xbar_port);
    else checks_passed++;
    tick();
    bus.req_valid  = 4'b0010;
    bus.out_enable = 4'hF;
    #1;
    checks_total++;
    if (bus.grant !== 4'b0010) $display("FAIL en_grant: got %b expected 0010", bus.grant);
    else checks_passed++;
    checks_total++;
    if (bus.xbar_port !== 8'h04) $display("FAIL en_xbar_port: got %h expected 04", bus.xbar_port);
    else checks_passed++;
    tick();
    bus.req_valid = 4'h0;
  endtask

  task automatic test_saturation();
    bus.req_valid = 4'b0011;
    bus.req_port  = 8'b00_00_10_10;
    repeat (65534) tick();
    checks_total++;
    if (cnt_of(2) !== 16'hFFFE) $display("FAIL sat_fffe: got %h expected fffe", cnt_of(2));
    else checks_passed++;
    tick();
    checks_total++;
    if (cnt_of(2) !== 16'hFFFF) $display("FAIL sat_ffff: got %h expected ffff", cnt_of(2));
    else checks_passed++;
    repeat (5) tick();
    checks_total++;
    if (cnt_of(2) !== 16'hFFFF) $display("FAIL sat_hold: got %h expected ffff", cnt_of(2));
    else checks_passed++;
    bus.clr_stats = 1'b1;
    tick();
    bus.clr_stats = 1'b0;
    checks_total++;
    if (cnt_of(2) !== 16'h0000) $display("FAIL clr_cnt2: got %h expected 0000", cnt_of(2));
    else checks_passed++;
    checks_total++;
    if (cnt_of(3) !== 16'h0000) $display("FAIL clr_cnt3: got %h expected 0000", cnt_of(3));
    else checks_passed++;
    tick();
    checks_total++;
    if (cnt_of(2) !== 16'h0001) $display("FAIL clr_resume: got %h expected 0001", cnt_of(2));
    else checks_passed++;
    bus.req_valid = 4'h0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_reset();
    test_permutation();
    test_round_robin();
    test_async_reset();
    test_backpressure();
    test_disable();
    test_saturation();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/xbar_scheduler.md
Name: xbar_scheduler

Overview:
- Conflict-free scheduler in front of the 4x4 cell crossbar.
- Takes one pending cell request per input port (valid + destination port) and grants at most one input per output each cycle, using a per-output round-robin arbiter.
- Drives the crossbar's valid_in/out_port controls so that no two inputs ever target the same output in one cycle.
- Returns a ready/grant handshake to each input queue and keeps saturating contention statistics.

Parameters:
- N_PORTS, 4, number of input and output ports; fixed at 4 in this revision.
- PORT_W, 2, width of a destination port index (log2 N_PORTS).
- CNT_W, 16, width of each per-output contention counter.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  4  bit i: input i holds a cell awaiting transfer.
- req_port  input  8  bits [2i+1:2i]: destination output of input i's cell.
- out_ready  input  4  bit j: output j can accept a cell this cycle.
- out_enable  input  4  bit j: output j administratively enabled.
- grant  output  4  bit i: input i's cell transfers at this rising edge (combinational).
- xbar_valid  output  4  to crossbar valid_in; equals grant.
- xbar_port  output  8  to crossbar out_port; equals req_port where granted, 0 elsewhere.
- contention_cnt  output  64  bits [16j+15:16j]: cycles in which output j had two or more requesters.
- clr_stats  input  1  synchronous clear of all contention counters.

Behaviour:
- Reset (rst_n low, async): all rr_ptr[j] = 0 and all contention_cnt = 0. grant, xbar_valid and xbar_port are combinational; with rr_ptr = 0 they follow the inputs, and no transfer completes while in reset.
- Eligibility: input i requests output j when req_valid[i] and req_port[i] == j. Output j is arbitrable only if out_ready[j] and out_enable[j].
- Arbitration per arbitrable output j: pick the first requesting input found scanning from rr_ptr[j] upward with wrap (rr_ptr, rr_ptr+1, ... mod 4). Exactly one winner, or none.
- Each input requests exactly one output, so grants are one-hot per output and at most one per input.
- Grant is same-cycle combinational, with zero added latency. Transfer happens on the rising edge where req_valid[i] && grant[i].
- The crossbar registers the cell at that same edge, so the cell appears at the output one cycle after the grant.
- Requester rule: req_valid and req_port must be held stable until granted. A requester may present its next cell in the cycle after the grant.
- Pointer update: on an edge where output j granted input k, rr_ptr[j] <= (k+1) mod 4. If output j made no grant, rr_ptr[j] holds. Wrap-around from 3 goes to 0.
- Fairness: any continuously asserted request to an output that is continuously ready and enabled is granted within 4 cycles.
- Blocked output (out_ready or out_enable low): no grant and pointer frozen; requesters to it simply wait. There is no head-of-line bypass, since each input has one request.
- Contention counting: if two or more inputs request output j in a cycle, contention_cnt[j] increments.
  - Counting happens regardless of out_ready/out_enable.
  - The counter saturates at 2^CNT_W-1 and never wraps.
- clr_stats: counters become 0 at the next edge. If clr_stats coincides with a contention event, the clear wins.
- Mid-operation reset: pointers and counters clear immediately. Any grant in a cycle ending with rst_n low is void, and the requester must retry after release.
- Asserting out_enable[j] has effect in the same cycle; it is treated as a plain combinational qualifier.

Decomposition:
- Shared package xbar_pkg:
  - N_PORTS and PORT_W constants.
  - port_idx_t typedef (PORT_W bits).
  - Function for the next round-robin index (mod N_PORTS).
- One natural sub-module, rr_arbiter4: 4-bit request vector in, 2-bit pointer register, one-hot grant out, advance-on-grant.
  - xbar_scheduler instantiates one rr_arbiter4 per output.
  - It builds each instance's request vector by decoding req_port and ORs the per-output grants into the per-input grant.

Test Plan:
- Reset then no requests: hold rst_n=0 for 3 cycles, then release with req_valid=0 → grant=0, xbar_valid=0, xbar_port=0, all contention_cnt=0.
- Non-conflicting permutation: req_valid=4'hF, ports (in0..3)=2,3,0,1, out_ready=out_enable=4'hF → grant=4'hF in one cycle, xbar_port=8'b01_00_11_10, contention_cnt unchanged.
- Full contention round-robin: all 4 inputs request output 1 and stay valid (each re-presents after grant) → grant sequence 0001, 0010, 0100, 1000, 0001; contention_cnt[1] increments every cycle.
- Backpressure: inputs 0 and 2 to output 3 with out_ready[3]=0 for 5 cycles → no grant, rr_ptr[3] frozen, contention_cnt[3]=5. Raise out_ready → input 0 granted, then input 2 next cycle.
- Disable plus partial: out_enable=4'b1101 with input1→output1 and input3→output0 → only grant[3]=1. Re-enable → input1 granted the same cycle.
- Saturation and clear: preload contention on output 2 for 65540 cycles → contention_cnt[2]=16'hFFFF. Pulse clr_stats while contention continues → counter reads 0 the next cycle.
- Async reset mid-stream: drop rst_n between edges during the round-robin test → pointers return to 0, so after release input 0 wins first.
